// File: rtl/debounce_edge_sync.sv
// Two-flop synchroniser plus a counting debouncer for a bouncy asynchronous input.
// Produces a clean level, one-cycle rise/fall pulses, a push-on/push-off toggle and a busy flag.
module debounce_edge_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             toggle_nxt;
    logic             busy_nxt;

    // The counter counts s2 samples of the candidate value already seen, so it starts at 1.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = level;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        toggle_nxt = toggle;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = HIGH;
                    level_nxt  = 1'b1;
                    rise_nxt   = 1'b1;
                    toggle_nxt = ~toggle;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end

    // Reset wins over every transition and clears the synchroniser too.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= LOW;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
            busy   <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            toggle <= toggle_nxt;
            busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_edge_sync.sv
// Bench for debounce_edge_sync: two instances (STABLE_CYCLES 4 and 2) on a shared input,
// checked against a sample-history model plus a fixed vector table and directed sequences.
module tb_debounce_edge_sync;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic din   = 1'b0;
    logic level4, rise4, fall4, toggle4, busy4;
    logic level2, rise2, fall2, toggle2, busy2;

    always #5 clock = ~clock;

    debounce_edge_sync #(.STABLE_CYCLES(4)) dut4 (
        .clock(clock), .reset(reset), .din(din),
        .level(level4), .rise(rise4), .fall(fall4), .toggle(toggle4), .busy(busy4)
    );

    debounce_edge_sync #(.STABLE_CYCLES(2)) dut2 (
        .clock(clock), .reset(reset), .din(din),
        .level(level2), .rise(rise2), .fall(fall2), .toggle(toggle2), .busy(busy2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (time %0t)", name, act, exp, $time);
    endtask

    // Model: the synchroniser is a two-sample delay; the level flips once the most recent
    // N synchronised samples all differ from it. Busy means a partial such run exists.
    localparam int HMAX = 8192;
    bit hist [2][HMAX];
    int hcnt   [2];
    int hstart [2];
    bit s1m [2], s2m [2], lvm [2], rsm [2], flm [2], tgm [2], bsm [2];

    task automatic model_step(input int m, input int n, input bit d, input bit r);
        int k;
        bit s;
        if (r) begin
            s1m[m] = 0; s2m[m] = 0; lvm[m] = 0; rsm[m] = 0;
            flm[m] = 0; tgm[m] = 0; bsm[m] = 0;
            hstart[m] = hcnt[m];
            return;
        end
        s = s2m[m];
        hist[m][hcnt[m]] = s;
        hcnt[m]++;
        k = 0;
        for (int i = hcnt[m] - 1; i >= hstart[m] && k < n; i--) begin
            if (hist[m][i] != lvm[m]) k++;
            else break;
        end
        rsm[m] = 0;
        flm[m] = 0;
        if (k == n) begin
            if (!lvm[m]) begin
                rsm[m] = 1;
                tgm[m] = ~tgm[m];
            end else begin
                flm[m] = 1;
            end
            lvm[m] = ~lvm[m];
            bsm[m] = 0;
        end else begin
            bsm[m] = (k > 0);
        end
        s2m[m] = s1m[m];
        s1m[m] = d;
    endtask

    int rise4_cnt, fall4_cnt, rise2_cnt;

    task automatic step(input logic d, input logic r);
        din   = d;
        reset = r;
        @(posedge clock);
        model_step(0, 4, d, r);
        model_step(1, 2, d, r);
        #1;
        check("model_n4", {3'b0, level4, rise4, fall4, toggle4, busy4},
              {3'b0, lvm[0], rsm[0], flm[0], tgm[0], bsm[0]});
        check("model_n2", {3'b0, level2, rise2, fall2, toggle2, busy2},
              {3'b0, lvm[1], rsm[1], flm[1], tgm[1], bsm[1]});
        if (rise4 && fall4) check("rise_fall_excl", 8'd1, 8'd0);
        rise4_cnt += int'(rise4);
        fall4_cnt += int'(fall4);
        rise2_cnt += int'(rise2);
    endtask

    typedef struct {
        logic       d;
        logic       r;
        logic [4:0] exp;  // {level, rise, fall, toggle, busy}
    } vec_t;

    vec_t tbl [15];

    initial begin
        // Basic press with N=4: first sampling edge of din=1 is row 7, level at row 12.
        for (int i = 0; i < 15; i++) begin
            tbl[i].d   = (i >= 7);
            tbl[i].r   = (i < 2);
            tbl[i].exp = 5'b00000;
        end
        for (int i = 9; i <= 11; i++) tbl[i].exp = 5'b00001;
        tbl[12].exp = 5'b11010;
        tbl[13].exp = 5'b10010;
        tbl[14].exp = 5'b10010;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].d, tbl[i].r);
            check($sformatf("vec%0d", i), {3'b0, level4, rise4, fall4, toggle4, busy4},
                  {3'b0, tbl[i].exp});
        end

        // Bounce rejection.
        step(0, 1); step(0, 1);
        rise4_cnt = 0;
        begin
            bit pat [7] = '{1, 1, 0, 1, 1, 1, 0};
            for (int i = 0; i < 7; i++) step(pat[i], 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0);
        check("bounce_rise_cnt", 8'(rise4_cnt), 8'd0);
        check("bounce_level", {7'b0, level4}, 8'd0);
        check("bounce_busy", {7'b0, busy4}, 8'd0);

        // Release and toggle: two press/release cycles.
        step(0, 1); step(0, 1);
        rise4_cnt = 0; fall4_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) step(1, 0);
            if (p == 0) check("toggle_after_press1", {7'b0, toggle4}, 8'd1);
            for (int i = 0; i < 10; i++) step(0, 0);
        end
        check("press_rise_cnt", 8'(rise4_cnt), 8'd2);
        check("press_fall_cnt", 8'(fall4_cnt), 8'd2);
        check("press_toggle_end", {7'b0, toggle4}, 8'd0);
        check("press_level_end", {7'b0, level4}, 8'd0);

        // Reset mid-qualification: WAIT_HIGH entered after edge E0+2, reset sampled at E0+4.
        step(0, 1); step(0, 1);
        rise4_cnt = 0;
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        check("midq_busy_before", {7'b0, busy4}, 8'd1);
        step(1, 1);
        check("midq_after_reset", {3'b0, level4, rise4, fall4, toggle4, busy4}, 8'd0);
        check("midq_no_rise_yet", 8'(rise4_cnt), 8'd0);
        for (int i = 0; i < 12; i++) step(1, 0);
        check("midq_rise_cnt", 8'(rise4_cnt), 8'd1);
        check("midq_toggle", {7'b0, toggle4}, 8'd1);

        // Reset while HIGH: level and toggle drop with no fall pulse, then requalify.
        check("rhigh_pre_level", {7'b0, level4}, 8'd1);
        fall4_cnt = 0; rise4_cnt = 0;
        step(1, 1);
        check("rhigh_after_reset", {3'b0, level4, rise4, fall4, toggle4, busy4}, 8'd0);
        for (int i = 0; i < 10; i++) step(1, 0);
        check("rhigh_fall_cnt", 8'(fall4_cnt), 8'd0);
        check("rhigh_rise_cnt", 8'(rise4_cnt), 8'd1);
        check("rhigh_level", {7'b0, level4}, 8'd1);

        // N=2 boundary: single-sample glitch rejected, two samples accepted 3 edges after E0.
        step(0, 1); step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
        rise2_cnt = 0;
        step(1, 0);
        for (int i = 0; i < 6; i++) step(0, 0);
        check("n2_glitch_rise_cnt", 8'(rise2_cnt), 8'd0);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        check("n2_e0p2_level", {7'b0, level2}, 8'd0);
        check("n2_e0p2_busy", {7'b0, busy2}, 8'd1);
        step(1, 0);
        check("n2_e0p3_level_rise", {6'b0, level2, rise2}, 8'b11);

        // Randomised runs of random length with occasional reset.
        for (int t = 0; t < 600; t++) begin
            bit d;
            int len;
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) step(d, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
